// File: rtl/glyph_row_serializer.sv
// rtl/glyph_row_serializer.sv - character ROM consumer: fetch glyph row, serialize scaled pixels
module glyph_row_serializer #(
    parameter int HSCALE  = 1,
    parameter int GLYPH_W = 5,
    parameter int GLYPH_H = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  char_code,
    input  logic [2:0]  glyph_row,
    output logic        ready,
    output logic [6:0]  rom_addr,
    input  logic [34:0] rom_data,
    input  logic        pix_en,
    output logic        pixel,
    output logic        pixel_valid,
    output logic        done
);

    localparam int         CELL_W   = GLYPH_W + 1;
    localparam logic [4:0] LAST_CNT = 5'(CELL_W * HSCALE - 1);
    localparam logic [4:0] HS       = 5'(HSCALE);
    localparam logic [2:0] ROWS     = 3'(GLYPH_H);

    typedef enum logic [1:0] {F_IDLE, F_ADDR, F_DATA, F_FULL} fstate_t;
    typedef enum logic       {S_IDLE, S_SHIFT} sstate_t;

    fstate_t     fstate_q, fstate_d;
    sstate_t     sstate_q, sstate_d;
    logic [6:0]  rom_addr_q, rom_addr_d;
    logic [2:0]  row_q, row_d;
    logic [4:0]  nxt_bits_q, nxt_bits_d;
    logic [4:0]  sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        load;
    logic        last_pix;
    logic        col_end;
    logic [4:0]  row_slice;

    assign ready       = (fstate_q == F_IDLE);
    assign rom_addr    = rom_addr_q;
    assign pixel_valid = (sstate_q == S_SHIFT);
    assign pixel       = pixel_valid & sh_q[4];
    assign done        = done_q;

    assign last_pix = (cnt_q == LAST_CNT);
    assign col_end  = ((cnt_q % HS) == (HS - 5'd1));

    // Row 7 (spacing row) and anything past the glyph height slice to blank.
    always_comb begin
        row_slice = 5'b00000;
        if (row_q < ROWS) begin
            case (row_q)
                3'd0:    row_slice = rom_data[34:30];
                3'd1:    row_slice = rom_data[29:25];
                3'd2:    row_slice = rom_data[24:20];
                3'd3:    row_slice = rom_data[19:15];
                3'd4:    row_slice = rom_data[14:10];
                3'd5:    row_slice = rom_data[9:5];
                3'd6:    row_slice = rom_data[4:0];
                default: row_slice = 5'b00000;
            endcase
        end
    end

    always_comb begin
        fstate_d   = fstate_q;
        sstate_d   = sstate_q;
        rom_addr_d = rom_addr_q;
        row_d      = row_q;
        nxt_bits_d = nxt_bits_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        load       = 1'b0;

        case (sstate_q)
            S_IDLE: begin
                if (fstate_q == F_FULL) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (pix_en) begin
                    if (last_pix) begin
                        done_d = 1'b1;
                        if (fstate_q == F_FULL) begin
                            load = 1'b1;
                        end else begin
                            sstate_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        // Zero shifts in, so the gap column falls out as 0 naturally.
                        if (col_end) begin
                            sh_d = {sh_q[3:0], 1'b0};
                        end
                    end
                end
            end
            default: sstate_d = S_IDLE;
        endcase

        if (load) begin
            sh_d     = nxt_bits_q;
            cnt_d    = 5'd0;
            sstate_d = S_SHIFT;
        end

        case (fstate_q)
            F_IDLE: begin
                if (start) begin
                    rom_addr_d = char_code;
                    row_d      = glyph_row;
                    fstate_d   = F_ADDR;
                end
            end
            F_ADDR:  fstate_d = F_DATA;
            F_DATA: begin
                nxt_bits_d = row_slice;
                fstate_d   = F_FULL;
            end
            F_FULL: begin
                if (load) begin
                    fstate_d = F_IDLE;
                end
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q   <= F_IDLE;
            sstate_q   <= S_IDLE;
            rom_addr_q <= 7'd32;
            row_q      <= 3'd0;
            nxt_bits_q <= 5'd0;
            sh_q       <= 5'd0;
            cnt_q      <= 5'd0;
            done_q     <= 1'b0;
        end else begin
            fstate_q   <= fstate_d;
            sstate_q   <= sstate_d;
            rom_addr_q <= rom_addr_d;
            row_q      <= row_d;
            nxt_bits_q <= nxt_bits_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_glyph_row_serializer.sv
// tb/tb_glyph_row_serializer.sv - directed vector bench for glyph_row_serializer
module tb_glyph_row_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [6:0]  char_code = 7'd0;
    logic [2:0]  glyph_row = 3'd0;
    logic        pix_en = 1'b0;

    logic        ready, pixel, pixel_valid, done;
    logic [6:0]  rom_addr;
    logic [34:0] rom_data = 35'd0;
    logic        ready2, pixel2, pixel_valid2, done2;
    logic [6:0]  rom_addr2;
    logic [34:0] rom_data2 = 35'd0;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    glyph_row_serializer #(.HSCALE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .char_code(char_code),
        .glyph_row(glyph_row), .ready(ready), .rom_addr(rom_addr),
        .rom_data(rom_data), .pix_en(pix_en), .pixel(pixel),
        .pixel_valid(pixel_valid), .done(done)
    );

    glyph_row_serializer #(.HSCALE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .char_code(char_code),
        .glyph_row(glyph_row), .ready(ready2), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .pix_en(pix_en), .pixel(pixel2),
        .pixel_valid(pixel_valid2), .done(done2)
    );

    function automatic logic [34:0] glyph(input logic [6:0] c);
        case (c)
            7'h41:   glyph = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
            7'h42:   glyph = {5'b11110, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b10001, 5'b11110};
            7'h5A:   glyph = {5'b10110, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111, 5'b00001};
            default: glyph = (c < 7'd32) ? 35'd0 : {35{1'b1}};
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data  <= glyph(rom_addr);
        rom_data2 <= glyph(rom_addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("wait_ready", 32'(ready), 32'd1);
    endtask

    task automatic wait_pv(input string tag, input logic use2);
        int k = 0;
        while (!(use2 ? pixel_valid2 : pixel_valid) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'd3);
    endtask

    task automatic run_cell(input string tag, input logic [6:0] code, input logic [2:0] row,
                            input logic [4:0] bits);
        logic [5:0] exp6;
        exp6 = {bits, 1'b0};
        wait_ready();
        char_code = code;
        glyph_row = row;
        pix_en    = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'(code));
        wait_pv(tag, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s pv[%0d]", tag, i), 32'(pixel_valid), 32'd1);
            chk($sformatf("%s pixel[%0d]", tag, i), 32'(pixel), 32'(exp6[5-i]));
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " idle"}, 32'(pixel_valid), 32'd0);
        @(negedge clk);
        chk({tag, " done_drop"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [6:0] code;
        logic [2:0] row;
        logic [4:0] bits;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [11:0] exp12;
        logic [4:0]  zbits;
        int          dn;

        vecs[0] = '{7'h41, 3'd0, 5'b01110};
        vecs[1] = '{7'h42, 3'd0, 5'b11110};
        vecs[2] = '{7'h41, 3'd7, 5'b00000};
        vecs[3] = '{7'h41, 3'd1, 5'b10001};
        vecs[4] = '{7'h41, 3'd3, 5'b11111};
        vecs[5] = '{7'h5A, 3'd6, 5'b00001};
        vecs[6] = '{7'h10, 3'd2, 5'b00000};
        vecs[7] = '{7'h7E, 3'd4, 5'b11111};

        // Reset asserted mid-cycle must take effect immediately.
        rst_n = 1'b1;
        #13;
        rst_n = 1'b0;
        #1;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst pv", 32'(pixel_valid), 32'd0);
        chk("rst pixel", 32'(pixel), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rom_addr", 32'(rom_addr), 32'h20);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_cell($sformatf("vec%0d", v), vecs[v].code, vecs[v].row, vecs[v].bits);
        end

        // Back-to-back: second start as soon as ready returns, no bubble.
        wait_ready();
        char_code = 7'h41; glyph_row = 3'd0; pix_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pv("b2b", 1'b0);
        chk("b2b ready", 32'(ready), 32'd1);
        char_code = 7'h42; start = 1'b1;
        exp12 = 12'b011100111100;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("b2b pv[%0d]", i), 32'(pixel_valid), 32'd1);
            chk($sformatf("b2b pixel[%0d]", i), 32'(pixel), 32'(exp12[11-i]));
            dn += int'(done);
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        dn += int'(done);
        chk("b2b done count", 32'(dn), 32'd2);
        @(negedge clk);

        // Stall at column 2 for five cycles.
        zbits = 5'b10110;
        wait_ready();
        char_code = 7'h5A; glyph_row = 3'd0; pix_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pv("stall", 1'b0);
        @(negedge clk);
        @(negedge clk);
        pix_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall hold pv[%0d]", i), 32'(pixel_valid), 32'd1);
            chk($sformatf("stall hold px[%0d]", i), 32'(pixel), 32'(zbits[2]));
            @(negedge clk);
        end
        chk("stall no done", 32'(done), 32'd0);
        pix_en = 1'b1;
        for (int c = 2; c < 6; c++) begin
            chk($sformatf("stall col%0d", c), 32'(pixel), (c < 5) ? 32'(zbits[4-c]) : 32'd0);
            chk($sformatf("stall pv col%0d", c), 32'(pixel_valid), 32'd1);
            @(negedge clk);
        end
        chk("stall done", 32'(done), 32'd1);
        @(negedge clk);

        // HSCALE=2 instance, row 10001.
        char_code = 7'h41; glyph_row = 3'd1; pix_en = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_pv("hs2", 1'b1);
        exp12 = 12'b110000001100;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("hs2 pv[%0d]", i), 32'(pixel_valid2), 32'd1);
            chk($sformatf("hs2 pixel[%0d]", i), 32'(pixel2), 32'(exp12[11-i]));
            @(negedge clk);
        end
        chk("hs2 done", 32'(done2), 32'd1);
        chk("hs2 idle", 32'(pixel_valid2), 32'd0);
        @(negedge clk);

        // Abort during the third pixel with a second fetch in flight.
        wait_ready();
        char_code = 7'h41; glyph_row = 3'd0; pix_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pv("abort", 1'b0);
        char_code = 7'h42; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort 3rd px", 32'(pixel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort pv", 32'(pixel_valid), 32'd0);
        chk("abort pixel", 32'(pixel), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort rom_addr", 32'(rom_addr), 32'h20);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            dn += int'(done) + int'(pixel_valid);
            @(negedge clk);
        end
        chk("abort quiet", 32'(dn), 32'd0);
        run_cell("post_abort", 7'h41, 3'd0, 5'b01110);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
